// File: rtl/bayer_pkg.sv
// Shared Bayer definitions: pattern codes, colour codes, default sample width
// and the encoder FSM state type.
package bayer_pkg;

   localparam int DATA_W = 10;

   // Pattern code is {row_flip, col_flip} applied to an RGGB base tile.
   localparam logic [1:0] PAT_RGGB = 2'd0;
   localparam logic [1:0] PAT_GRBG = 2'd1;
   localparam logic [1:0] PAT_GBRG = 2'd2;
   localparam logic [1:0] PAT_BGGR = 2'd3;

   localparam logic [1:0] COL_R = 2'd0;
   localparam logic [1:0] COL_G = 2'd1;
   localparam logic [1:0] COL_B = 2'd2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } enc_state_t;

   // Colour of a site from its flipped row/column parities.
   function automatic logic [1:0] bayer_color(input logic pr, input logic pc);
      if (pr & pc)      return COL_B;
      else if (pr ^ pc) return COL_G;
      else              return COL_R;
   endfunction

endpackage

// File: rtl/bayer_skid_buffer.sv
// Two-entry valid/ready register slice: an output register plus one skid entry,
// with a registered upstream ready that drops only when both entries are held.
module bayer_skid_buffer #(
   parameter int W = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_s_valid,
   output logic         o_s_ready,
   input  logic [W-1:0] i_s_data,
   output logic         o_m_valid,
   input  logic         i_m_ready,
   output logic [W-1:0] o_m_data
);

   logic         r_out_vld;
   logic         r_skid_vld;
   logic         r_ready;
   logic [W-1:0] r_out;
   logic [W-1:0] r_skid;

   logic w_push;
   logic w_pop;
   logic w_out_free;
   logic w_out_vld_nx;
   logic w_skid_vld_nx;

   // The skid entry is only ever occupied while the output register is, and a
   // full slice refuses input, so a push never coincides with a skid refill.
   always_comb begin
      w_push        = i_s_valid & r_ready;
      w_pop         = r_out_vld & i_m_ready;
      w_out_free    = ~r_out_vld | w_pop;
      w_out_vld_nx  = w_out_free ? (r_skid_vld | w_push) : 1'b1;
      w_skid_vld_nx = w_out_free ? 1'b0 : (r_skid_vld | w_push);
   end

   always_ff @(posedge clk) begin
      // NOTE: payload registers are reset too so the output bus reads zero after reset.
      if (rst) begin
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
         r_ready    <= 1'b1;
         r_out      <= '0;
         r_skid     <= '0;
      end else begin
         r_out_vld  <= w_out_vld_nx;
         r_skid_vld <= w_skid_vld_nx;
         r_ready    <= ~(w_out_vld_nx & w_skid_vld_nx);
         if (w_out_free) begin
            if (r_skid_vld)  r_out <= r_skid;
            else if (w_push) r_out <= i_s_data;
         end else if (w_push) begin
            r_skid <= i_s_data;
         end
      end
   end

   assign o_s_ready = r_ready;
   assign o_m_valid = r_out_vld;
   assign o_m_data  = r_out;

endmodule

// File: rtl/bayer_mosaic_encoder.sv
// Re-mosaics an RGB pixel stream into a single-channel Bayer stream, tracking
// frame position from sof/eol sideband and flagging framing errors.
module bayer_mosaic_encoder #(
   parameter int DATA_W = bayer_pkg::DATA_W,
   parameter int IMG_W  = 1920,
   parameter int IMG_H  = 1080,
   parameter int CNT_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cfg_pattern,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_r,
   input  logic [DATA_W-1:0] s_g,
   input  logic [DATA_W-1:0] s_b,
   input  logic              s_sof,
   input  logic              s_eol,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [1:0]        m_color,
   output logic              m_sof,
   output logic              m_eol,
   output logic              m_eof,
   output logic              err_sync
);

   import bayer_pkg::*;

   localparam int PL_W = DATA_W + 5;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

   enc_state_t       r_state;
   logic [CNT_W-1:0] r_col;
   logic [CNT_W-1:0] r_row;
   logic [1:0]       r_pat;
   logic             r_err;

   logic              w_s_ready;
   logic              w_accept;
   logic              w_emit;
   logic              w_push;
   logic              w_last_col;
   logic              w_eol;
   logic              w_eof;
   logic              w_bad;
   logic [CNT_W-1:0]  w_col;
   logic [CNT_W-1:0]  w_row;
   logic [1:0]        w_pat;
   logic [1:0]        w_color;
   logic [DATA_W-1:0] w_data;
   logic [PL_W-1:0]   w_in_pl;
   logic [PL_W-1:0]   w_out_pl;

   // A sof beat is always pixel (0,0) under the freshly sampled pattern,
   // whether it opens a frame or restarts one.
   always_comb begin
      // NOTE: every combinational output gets a value on every path, so no latches.
      w_accept   = s_valid & w_s_ready;
      w_emit     = s_sof | (r_state == ST_ACTIVE);
      w_push     = w_accept & w_emit;
      w_pat      = s_sof ? cfg_pattern : r_pat;
      w_col      = s_sof ? '0 : r_col;
      w_row      = s_sof ? '0 : r_row;
      w_last_col = (w_col == LAST_COL);
      w_eol      = s_eol | w_last_col;
      w_eof      = w_eol & (w_row == LAST_ROW);
      w_bad      = (s_sof ? (r_state == ST_ACTIVE) : (r_state == ST_IDLE))
                 | (w_emit & (s_eol != w_last_col));
      w_color    = bayer_color(w_row[0] ^ w_pat[1], w_col[0] ^ w_pat[0]);
      w_data     = '0;
      unique case (w_color)
         COL_R:   w_data = s_r;
         COL_G:   w_data = s_g;
         COL_B:   w_data = s_b;
         default: w_data = '0;
      endcase
      w_in_pl = {w_data, w_color, s_sof, w_eol, w_eof};
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
      if (rst) begin
         r_state <= ST_IDLE;
         r_col   <= '0;
         r_row   <= '0;
         r_pat   <= PAT_RGGB;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         if (w_bad) r_err <= 1'b1;
         if (w_emit) begin
            r_pat <= w_pat;
            if (w_eof) begin
               r_state <= ST_IDLE;
               r_col   <= '0;
               r_row   <= '0;
            end else if (w_eol) begin
               r_state <= ST_ACTIVE;
               r_col   <= '0;
               r_row   <= w_row + CNT_W'(1);
            end else begin
               r_state <= ST_ACTIVE;
               r_col   <= w_col + CNT_W'(1);
               r_row   <= w_row;
            end
         end
      end
   end

   bayer_skid_buffer #(.W(PL_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .i_s_valid (w_push),
      .o_s_ready (w_s_ready),
      .i_s_data  (w_in_pl),
      .o_m_valid (m_valid),
      .i_m_ready (m_ready),
      .o_m_data  (w_out_pl)
   );

   assign s_ready  = w_s_ready;
   assign {m_data, m_color, m_sof, m_eol, m_eof} = w_out_pl;
   assign err_sync = r_err;

endmodule

// File: tb/tb_bayer_mosaic_encoder.sv
// Directed bench for bayer_mosaic_encoder on a 4x2 frame: table-driven frames,
// backpressure, framing errors, pattern latching and mid-frame reset.
module tb_bayer_mosaic_encoder;
   import bayer_pkg::*;

   localparam int DW = 10;
   localparam int IW = 4;
   localparam int IH = 2;
   localparam int CW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    cfg_pattern = 2'd0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_r = '0, s_g = '0, s_b = '0;
   logic          s_sof = 1'b0, s_eol = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic [1:0]    m_color;
   logic          m_sof, m_eol, m_eof;
   logic          err_sync;

   always #5 clk = ~clk;

   bayer_mosaic_encoder #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern),
      .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b),
      .s_sof(s_sof), .s_eol(s_eol),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_color(m_color),
      .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .err_sync(err_sync)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    color;
      logic          sof;
      logic          eol;
      logic          eof;
   } out_t;

   typedef struct {
      logic [DW-1:0] r, g, b;
      logic          sof, eol;
      out_t          exp;
   } vec_t;

   vec_t tbl [8];
   out_t exp_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_beat = 0;
   int   occ = 0;
   int   rdy_mode = 0;
   logic tb_emit = 1'b0;
   logic mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pixel n carries r=n, g=100+n, b=200+n; expected sample follows the given colour.
   function automatic vec_t mk(input int n, input logic sof, input logic eol,
                               input logic [1:0] col, input logic eeol, input logic eeof);
      vec_t v;
      v.r = DW'(n);
      v.g = DW'(100 + n);
      v.b = DW'(200 + n);
      v.sof = sof;
      v.eol = eol;
      case (col)
         2'd0:    v.exp.data = DW'(n);
         2'd1:    v.exp.data = DW'(100 + n);
         default: v.exp.data = DW'(200 + n);
      endcase
      v.exp.color = col;
      v.exp.sof   = sof;
      v.exp.eol   = eeol;
      v.exp.eof   = eeof;
      return v;
   endfunction

   // Clean 4x2 frame whose 2x2 tile colours are given by hand.
   task automatic fill_frame(input logic [1:0] c00, c01, c10, c11);
      for (int i = 0; i < 8; i++) begin
         int row, col;
         logic [1:0] c;
         row = i / 4;
         col = i % 4;
         c = (row % 2 == 1) ? ((col % 2 == 1) ? c11 : c10) : ((col % 2 == 1) ? c01 : c00);
         tbl[i] = mk(i, i == 0, col == 3, c, col == 3, i == 7);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Holds one beat until it is accepted (bounded), then returns at posedge+1.
   task automatic send(input vec_t v, input logic emit);
      int   budget;
      logic ok;
      s_valid = 1'b1;
      s_r = v.r; s_g = v.g; s_b = v.b;
      s_sof = v.sof; s_eol = v.eol;
      tb_emit = emit;
      budget = 0;
      ok = 1'b0;
      while (!ok && budget < 500) begin
         @(negedge clk);
         ok = s_ready;
         budget++;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: s_ready stuck at %0b, required 1", s_ready);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      tb_emit = 1'b0;
   endtask

   task automatic run_tbl(input int n, input int gap_max);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(tbl[i].exp);
         send(tbl[i], 1'b1);
         if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
   endtask

   task automatic wait_drain(input string name);
      int b;
      b = 0;
      while ((exp_q.size() != 0 || occ != 0) && b < 300) begin
         @(posedge clk);
         b++;
      end
      #1;
      check(name, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         default: m_ready = 1'b0;
      endcase
   end

   // Output monitor: in-order scoreboard, stall stability and occupancy model.
   out_t last_out;
   logic stalled = 1'b0;
   always @(negedge clk) begin
      out_t cur;
      if (mon_en) begin
         if (rst) begin
            occ = 0;
            stalled = 1'b0;
         end else begin
            cur = {m_data, m_color, m_sof, m_eol, m_eof};
            check("s_ready_vs_occupancy", s_ready, occ != 2);
            check("m_valid_vs_occupancy", m_valid, occ != 0);
            if (stalled) check("stall_hold", {m_valid, cur}, {1'b1, last_out});
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got %0h, expected no beat", cur);
               end else begin
                  check($sformatf("beat%0d", n_beat), cur, exp_q.pop_front());
               end
               n_beat++;
            end
            stalled  = m_valid & ~m_ready;
            last_out = cur;
            occ = occ + int'(s_valid & s_ready & tb_emit) - int'(m_valid & m_ready);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_color", m_color, 0);
      check("rst_flags", {m_sof, m_eol, m_eof}, 0);
      check("rst_err_sync", err_sync, 0);
      check("rst_s_ready", s_ready, 1);
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // T1: RGGB frame, always-ready sink.
      cfg_pattern = PAT_RGGB;
      fill_frame(COL_R, COL_G, COL_G, COL_B);
      run_tbl(8, 0);
      wait_drain("t1_drain");
      check("t1_err_sync", err_sync, 0);

      // T2: BGGR frame.
      cfg_pattern = PAT_BGGR;
      fill_frame(COL_B, COL_G, COL_G, COL_R);
      run_tbl(8, 0);
      wait_drain("t2_drain");

      // T3: toggling m_ready, back-to-back then with random input gaps.
      cfg_pattern = PAT_RGGB;
      fill_frame(COL_R, COL_G, COL_G, COL_B);
      rdy_mode = 1;
      run_tbl(8, 0);
      run_tbl(8, 2);
      wait_drain("t3_drain");
      rdy_mode = 0;
      check("t3_err_sync", err_sync, 0);

      // T5: pattern change mid-frame only applies from the next sof.
      cfg_pattern = PAT_RGGB;
      fill_frame(COL_R, COL_G, COL_G, COL_B);
      for (int i = 0; i < 8; i++) begin
         if (i == 2) cfg_pattern = PAT_GRBG;
         exp_q.push_back(tbl[i].exp);
         send(tbl[i], 1'b1);
      end
      fill_frame(COL_G, COL_R, COL_B, COL_G);
      run_tbl(8, 0);
      wait_drain("t5_drain");
      check("t5_err_sync", err_sync, 0);

      // T4a: early eol at col 2 resyncs to row 1 col 0.
      do_reset();
      cfg_pattern = PAT_RGGB;
      tbl[0] = mk(0, 1'b1, 1'b0, COL_R, 1'b0, 1'b0);
      tbl[1] = mk(1, 1'b0, 1'b0, COL_G, 1'b0, 1'b0);
      tbl[2] = mk(2, 1'b0, 1'b1, COL_R, 1'b1, 1'b0);
      tbl[3] = mk(3, 1'b0, 1'b0, COL_G, 1'b0, 1'b0);
      tbl[4] = mk(4, 1'b0, 1'b0, COL_B, 1'b0, 1'b0);
      tbl[5] = mk(5, 1'b0, 1'b0, COL_G, 1'b0, 1'b0);
      tbl[6] = mk(6, 1'b0, 1'b1, COL_B, 1'b1, 1'b1);
      @(negedge clk);
      check("t4a_err_before", err_sync, 0);
      @(posedge clk);
      #1;
      run_tbl(7, 0);
      wait_drain("t4a_drain");
      check("t4a_err_sync", err_sync, 1);

      // T4b: missing eol on the last column is treated as eol and flagged.
      do_reset();
      fill_frame(COL_R, COL_G, COL_G, COL_B);
      tbl[3].eol = 1'b0;
      run_tbl(8, 0);
      wait_drain("t4b_drain");
      check("t4b_err_sync", err_sync, 1);

      // T4c: beats without a preceding sof are dropped.
      do_reset();
      fill_frame(COL_R, COL_G, COL_G, COL_B);
      for (int i = 1; i < 4; i++) send(tbl[i], 1'b0);
      idle(3);
      check("t4c_err_sync", err_sync, 1);
      check("t4c_nothing_out", m_valid, 0);
      run_tbl(8, 0);
      wait_drain("t4c_recover_drain");

      // T6: reset with both entries held, then a clean frame replays T1.
      do_reset();
      fill_frame(COL_R, COL_G, COL_G, COL_B);
      rdy_mode = 2;
      idle(1);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(tbl[i].exp);
         send(tbl[i], 1'b1);
      end
      @(negedge clk);
      check("t6_full_s_ready", s_ready, 0);
      check("t6_full_m_valid", m_valid, 1);
      @(posedge clk);
      #1;
      do_reset();
      @(negedge clk);
      check("t6_flush_m_valid", m_valid, 0);
      check("t6_flush_s_ready", s_ready, 1);
      rdy_mode = 0;
      @(posedge clk);
      #1;
      run_tbl(8, 0);
      wait_drain("t6_replay_drain");
      check("t6_err_sync", err_sync, 0);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
